alarm_scheduler: RTL
====================

# alarm_scheduler

Multi-slot alarm controller for the digital clock. Holds N_SLOT programmable alarm times, compares them once per second against the running BCD time, arbitrates simultaneous hits, and sequences the shared ring output (which drives `light_on`) through ring, snooze and timeout phases. It sits between the timekeeping counters and the light/display blocks and replaces single-alarm compare logic in `top`.

## Interface
- N_SLOT, 4, number of alarm slots; fixed at 4 by the 2-bit slot fields.
- RING_SEC, 60, seconds a ring lasts before auto-stop.
- SNOOZE_SEC, 300, snooze length in seconds.
- MAX_SNOOZE, 3, snoozes allowed per ring event.

Ports:
- clk_sys  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- sec_tick  in  1  one-cycle pulse per second, clk_sys domain.
- cur_time  in  20  packed BCD {hou_h[1:0],hou_l[3:0],min_h[2:0],min_l[3:0],sec_h[2:0],sec_l[3:0]}; holds the new second in any cycle where sec_tick=1.
- cfg_we  in  1  write strobe for slot configuration.
- cfg_slot  in  2  slot written.
- cfg_time  in  20  alarm time, same packing as cur_time.
- cfg_en  in  1  enable bit written with cfg_time.
- snooze_req  in  1  one-cycle pulse from button_detect.
- stop_req  in  1  one-cycle pulse from button_detect.
- rd_slot  in  2  readback select.
- rd_time  out  20  combinational slot time for rd_slot.
- slot_en  out  4  per-slot enable flags.
- ring  out  1  level, high while ringing.
- ring_slot  out  2  slot currently ringing or snoozing.
- snoozing  out  1  high in SNOOZE.
- pending  out  4  slots that matched and await service.

## Operation
- Reset: all slot times 0, slot_en=0, pending=0, ring=0, ring_slot=0, snoozing=0, snooze count 0, second counter 0, state IDLE.
- Config: on cfg_we, slot[cfg_slot] gets cfg_time and cfg_en next cycle. Writing the active (ringing/snoozing) slot cancels it exactly as stop_req does. Writing any slot clears its pending bit.
- Match: in a cycle with sec_tick=1, slot i hits when slot_en[i] and time[i]==cur_time. Hits set pending[i], except for the active slot while RING or SNOOZE. The compare is 20-bit equality on packed BCD. Values are never range-checked.
- States:
  - IDLE: if pending is non-zero, go to RING with ring_slot = lowest set pending index. Clear that pending bit, clear the second counter, set snooze count 0.
  - RING: ring=1.
    - stop_req: leave RING.
    - snooze_req with snooze count < MAX_SNOOZE: go to SNOOZE, increment snooze count, clear the second counter.
    - snooze_req with snooze count = MAX_SNOOZE: acts as stop_req.
    - Counter reaches RING_SEC on a sec_tick: auto-stop.
  - SNOOZE: ring=0, snoozing=1.
    - stop_req: leave SNOOZE.
    - Counter reaches SNOOZE_SEC on a sec_tick: go to RING with the counter cleared and the snooze count kept.
    - snooze_req: ignored.
  - Leaving RING/SNOOZE: go to IDLE. IDLE picks up any pending slot on the following cycle.
- Simultaneous events:
  - stop_req beats snooze_req.
  - A request beats sec_tick timeout in the same cycle.
  - cfg_we cancel beats a snooze transition.
  - A hit from a non-active slot always registers in pending.
- ring_slot holds its last value in IDLE.

## Timing
- Match to ring: pending sets one cycle after the sec_tick cycle. ring rises one cycle later, 2 cycles after sec_tick.
- Requests act on the cycle they are sampled. State and outputs change next cycle. Button pulses are assumed single-cycle and are not edge-detected again.
- Second counter increments only on sec_tick. Its width is clog2(SNOOZE_SEC+1) and it saturates at its terminal count.
- Auto-stop: ring falls on the cycle after the RING_SEC-th sec_tick counted in RING.
- Back-to-back service: after stop, the next pending slot rings 2 cycles later (IDLE for one cycle).
- rst takes effect on the next clk_sys edge regardless of state, including mid-ring and mid-snooze.

## Test plan
- Slot 0 = 07:30:00, enabled. Drive cur_time to 07:30:00 with sec_tick. ring=1 and ring_slot=0 two cycles later; stop_req drops ring next cycle.
- Slots 1 and 3 both = 12:00:00. On hit, pending=1010. Slot 1 rings first. After stop_req, slot 3 rings 2 cycles later and pending=0000.
- RING_SEC=5, no buttons: ring falls after the 5th sec_tick. Slot not re-rung.
- Four snooze_req in sequence, each followed by SNOOZE_SEC ticks: first three enter SNOOZE and re-ring. The fourth stops and returns to IDLE.
- Same cycle:
  - snooze_req + stop_req in RING → IDLE.
  - cfg_we to the active slot during SNOOZE → snoozing=0, IDLE.
- Disabled slot matching → no pending. rst during RING → all outputs 0 next cycle, slot_en=0. rd_time mirrors the written cfg_time.

Source files
------------

// File: rtl/alarm_scheduler.sv
// Multi-slot alarm controller: per-second BCD compare against N_SLOT programmable alarms,
// lowest-index arbitration, and a ring / snooze / timeout sequencer for the shared ring output.
module alarm_scheduler #(
  parameter int unsigned N_SLOT     = 4,
  parameter int unsigned RING_SEC   = 60,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned MAX_SNOOZE = 3
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              sec_tick,
  input  logic [19:0]       cur_time,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_slot,
  input  logic [19:0]       cfg_time,
  input  logic              cfg_en,
  input  logic              snooze_req,
  input  logic              stop_req,
  input  logic [1:0]        rd_slot,
  output logic [19:0]       rd_time,
  output logic [N_SLOT-1:0] slot_en,
  output logic              ring,
  output logic [1:0]        ring_slot,
  output logic              snoozing,
  output logic [N_SLOT-1:0] pending
);

  localparam int unsigned CntW = $clog2(SNOOZE_SEC + 1);
  localparam int unsigned SnzW = $clog2(MAX_SNOOZE + 1);
  localparam logic [CntW-1:0] RingTc   = CntW'(RING_SEC);
  localparam logic [CntW-1:0] SnoozeTc = CntW'(SNOOZE_SEC);
  localparam logic [SnzW-1:0] SnzMax   = SnzW'(MAX_SNOOZE);

  typedef enum logic [1:0] {StIdle, StRing, StSnooze} state_e;

  state_e            state_q;
  logic [19:0]       time_q [N_SLOT];
  logic [N_SLOT-1:0] slot_en_q;
  logic [N_SLOT-1:0] pending_q;
  logic [N_SLOT-1:0] pending_d;
  logic [N_SLOT-1:0] hit;
  logic [1:0]        ring_slot_q;
  logic [1:0]        low_idx;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   cnt_inc;
  logic [CntW-1:0]   cnt_sat;
  logic [SnzW-1:0]   snz_q;
  logic              active;
  logic              cfg_cancel;

  assign active     = (state_q != StIdle);
  assign cfg_cancel = cfg_we && active && (cfg_slot == ring_slot_q);
  assign cnt_inc    = cnt_q + CntW'(1);
  assign cnt_sat    = (cnt_q == '1) ? cnt_q : cnt_inc;

  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(N_SLOT); i++) begin
      if (sec_tick && slot_en_q[i] && (time_q[i] == cur_time)) hit[i] = 1'b1;
    end
    // The slot being serviced must not re-queue itself while it rings or snoozes.
    if (active) hit[ring_slot_q] = 1'b0;
  end

  always_comb begin
    low_idx = '0;
    for (int i = int'(N_SLOT) - 1; i >= 0; i--) begin
      if (pending_q[i]) low_idx = 2'(i);
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (cfg_we) pending_d[cfg_slot] = 1'b0;
    if (!active && (pending_q != '0)) pending_d[low_idx] = 1'b0;
    pending_d = pending_d | hit;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q     <= StIdle;
      for (int i = 0; i < int'(N_SLOT); i++) time_q[i] <= '0;
      slot_en_q   <= '0;
      pending_q   <= '0;
      ring_slot_q <= '0;
      cnt_q       <= '0;
      snz_q       <= '0;
    end else begin
      if (cfg_we) begin
        time_q[cfg_slot]    <= cfg_time;
        slot_en_q[cfg_slot] <= cfg_en;
      end
      pending_q <= pending_d;

      unique case (state_q)
        StIdle: begin
          if (pending_q != '0) begin
            state_q     <= StRing;
            ring_slot_q <= low_idx;
            cnt_q       <= '0;
            snz_q       <= '0;
          end
        end
        StRing: begin
          // Priority: stop / cancel, then snooze, then the second-based timeout.
          if (stop_req || cfg_cancel) begin
            state_q <= StIdle;
          end else if (snooze_req) begin
            if (snz_q < SnzMax) begin
              state_q <= StSnooze;
              snz_q   <= snz_q + SnzW'(1);
              cnt_q   <= '0;
            end else begin
              state_q <= StIdle;
            end
          end else if (sec_tick) begin
            if (cnt_inc == RingTc) state_q <= StIdle;
            else                   cnt_q   <= cnt_sat;
          end
        end
        StSnooze: begin
          if (stop_req || cfg_cancel) begin
            state_q <= StIdle;
          end else if (sec_tick) begin
            if (cnt_inc == SnoozeTc) begin
              state_q <= StRing;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_sat;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rd_time   = time_q[rd_slot];
  assign slot_en   = slot_en_q;
  assign ring      = (state_q == StRing);
  assign snoozing  = (state_q == StSnooze);
  assign ring_slot = ring_slot_q;
  assign pending   = pending_q;

endmodule
